// File: rtl/mmu_pkg.sv
// Shared MMU definitions: memory port geometry and the port-B arbiter state
// encoding used by memb_arbiter.
package mmu_pkg;

  localparam int MEM_AW = 14;
  localparam int MEM_DW = 64;

  typedef enum logic [1:0] {
    ST_ARB  = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_e;

endpackage

// File: rtl/memb_rd_tag_pipe.sv
// Read-return tag pipeline for the port-B arbiter.
// Tracks each accepted read through the memory latency and raises the
// owner's rvalid when its data appears on doutb.
//   clk, rst      : clock, synchronous active-high reset (clears valid bits)
//   push_vld_i    : a read was accepted this cycle
//   push_owner_i  : requester index of that read (0/1)
//   rvalid0_o/1_o : read data for requester 0/1 is on doutb this cycle
module memb_rd_tag_pipe #(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic push_vld_i,
  input  logic push_owner_i,
  output logic rvalid0_o,
  output logic rvalid1_o
);

  // Stage 0 lines up with the registered enb; RD_LAT further stages line up
  // with doutb.
  localparam int DEPTH = RD_LAT + 1;

  logic [DEPTH-1:0] vld_q;
  logic [DEPTH-1:0] own_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
    end else begin
      vld_q <= {vld_q[DEPTH-2:0], push_vld_i};
    end
  end

  // Owner bits are only meaningful alongside a set valid bit.
  always_ff @(posedge clk) begin
    own_q <= {own_q[DEPTH-2:0], push_owner_i};
  end

  assign rvalid0_o = vld_q[DEPTH-1] & ~own_q[DEPTH-1];
  assign rvalid1_o = vld_q[DEPTH-1] &  own_q[DEPTH-1];

endmodule

// File: rtl/memb_arbiter.sv
// Two-requester round-robin arbiter for memory port B inside the mmu.
// Requester 0 is the SPART driver, requester 1 the debug/display reader.
// A requester may lock the port for multi-beat sequences. The memory command
// is registered; read data returns on rdata with the owner's rvalid
// RD_LAT+1 cycles after acceptance.
//   clk, rst                              : clock, synchronous active-high reset
//   req*/lock*/we*/addr*/wdata* (inputs)  : per-requester command
//   gnt* (outputs)                        : command accepted this cycle (combinational)
//   rvalid* (outputs)                     : rdata belongs to that requester
//   rdata                                 : doutb passed straight through
//   enb/web/addrb/dinb, doutb             : BRAM port B
module memb_arbiter
  import mmu_pkg::*;
#(
  parameter int AW     = MEM_AW,
  parameter int DW     = MEM_DW,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          lock0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          gnt0,
  output logic          rvalid0,
  input  logic          req1,
  input  logic          lock1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt1,
  output logic          rvalid1,
  output logic [DW-1:0] rdata,
  output logic          enb,
  output logic          web,
  output logic [AW-1:0] addrb,
  output logic [DW-1:0] dinb,
  input  logic [DW-1:0] doutb
);

  arb_state_e    state_q, state_d;
  logic          last_q, last_d;
  logic          acc0, acc1, acc;
  logic          cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          enb_q, web_q;
  logic [AW-1:0] addrb_q;
  logic [DW-1:0] dinb_q;

  always_comb begin
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    state_d = state_q;
    last_d  = last_q;

    if (!rst) begin
      case (state_q)
        ST_ARB: begin
          if (req0 && req1) begin
            // Tie goes to whoever did not win last.
            gnt0 = last_q;
            gnt1 = !last_q;
          end else begin
            gnt0 = req0;
            gnt1 = req1;
          end
        end
        ST_OWN0: gnt0 = req0;
        ST_OWN1: gnt1 = req1;
        default: ;
      endcase
    end

    acc0 = req0 & gnt0;
    acc1 = req1 & gnt1;

    if (acc0) last_d = 1'b0;
    if (acc1) last_d = 1'b1;

    case (state_q)
      ST_ARB: begin
        if (acc0 && lock0)      state_d = ST_OWN0;
        else if (acc1 && lock1) state_d = ST_OWN1;
      end
      // In OWNx the owner is granted whenever it requests, so dropping lock
      // covers both exits: accepted with lock=0, or idle with lock abandoned.
      // The other requester is only seen once back in ARB (next cycle).
      ST_OWN0: if (!lock0) state_d = ST_ARB;
      ST_OWN1: if (!lock1) state_d = ST_ARB;
      default: state_d = ST_ARB;
    endcase
  end

  assign acc       = acc0 | acc1;
  assign cmd_we    = acc1 ? we1    : we0;
  assign cmd_addr  = acc1 ? addr1  : addr0;
  assign cmd_wdata = acc1 ? wdata1 : wdata0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_ARB;
      last_q  <= 1'b1;
      enb_q   <= 1'b0;
      web_q   <= 1'b0;
      addrb_q <= '0;
      dinb_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      enb_q   <= acc;
      web_q   <= acc & cmd_we;
      // Address and data hold their last values when idle.
      if (acc) begin
        addrb_q <= cmd_addr;
        dinb_q  <= cmd_wdata;
      end
    end
  end

  assign enb   = enb_q;
  assign web   = web_q;
  assign addrb = addrb_q;
  assign dinb  = dinb_q;
  assign rdata = doutb;

  memb_rd_tag_pipe #(
    .RD_LAT(RD_LAT)
  ) u_tag_pipe (
    .clk         (clk),
    .rst         (rst),
    .push_vld_i  (acc & ~cmd_we),
    .push_owner_i(acc1),
    .rvalid0_o   (rvalid0),
    .rvalid1_o   (rvalid1)
  );

endmodule
